// File: rtl/encoder_pkg.sv
// encoder_pkg: shared definitions for the RV32I instruction encoder/loader.
//   - descriptor class codes (0..9 legal, 10..15 illegal)
//   - the nine 7-bit RV32I major opcodes
//   - loader FSM state type
//   - canonical NOP word and a signed-range helper
package encoder_pkg;

   localparam logic [3:0] CLS_R      = 4'd0;
   localparam logic [3:0] CLS_IALU   = 4'd1;
   localparam logic [3:0] CLS_LOAD   = 4'd2;
   localparam logic [3:0] CLS_STORE  = 4'd3;
   localparam logic [3:0] CLS_BRANCH = 4'd4;
   localparam logic [3:0] CLS_LUI    = 4'd5;
   localparam logic [3:0] CLS_AUIPC  = 4'd6;
   localparam logic [3:0] CLS_JAL    = 4'd7;
   localparam logic [3:0] CLS_JALR   = 4'd8;
   localparam logic [3:0] CLS_LI     = 4'd9;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE,
      HOLD,
      HOLD_LUI
   } state_e;

   // True when v, read as a signed 32-bit value, fits in a bits-wide signed field.
   function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
      int lim;
      lim = 1 << (bits - 1);
      return ($signed(v) >= -lim) && ($signed(v) < lim);
   endfunction

endpackage

// File: rtl/instr_field_packer.sv
// instr_field_packer: combinational encoder from a decoded descriptor to RV32I words.
//   cls/rd/rs1/rs2/funct3/alt/imm : descriptor fields
//   word      : first (or only) word to write
//   lui_word  : LUI half of an LI expansion
//   addi_word : ADDI half of an LI expansion
//   two_word  : LI needs LUI followed by ADDI
//   range_err : immediate does not fit the class's field
//   illegal   : class code 10..15
module instr_field_packer
   import encoder_pkg::*;
(
   input  logic [3:0]  cls,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [2:0]  funct3,
   input  logic        alt,
   input  logic [31:0] imm,
   output logic [31:0] word,
   output logic [31:0] lui_word,
   output logic [31:0] addi_word,
   output logic        two_word,
   output logic        range_err,
   output logic        illegal
);

   logic [6:0]  f7;
   logic [19:0] li_hi;
   logic        is_shift;

   assign f7       = alt ? 7'b0100000 : 7'b0000000;
   assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
   // (imm + 0x800) >> 12 only needs the upper 20 bits plus the carry out of bit 11.
   assign li_hi    = imm[31:12] + {19'd0, imm[11]};

   always_comb begin
      word      = NOP;
      lui_word  = {li_hi, rd, OPC_LUI};
      addi_word = {imm[11:0], rd, 3'b000, rd, OPC_I};
      two_word  = 1'b0;
      range_err = 1'b0;
      illegal   = 1'b0;
      case (cls)
         CLS_R: word = {f7, rs2, rs1, funct3, rd, OPC_R};
         CLS_IALU: begin
            if (is_shift) begin
               range_err = |imm[31:5];
               word      = {f7, imm[4:0], rs1, funct3, rd, OPC_I};
            end else begin
               range_err = !fits_signed(imm, 12);
               word      = {imm[11:0], rs1, funct3, rd, OPC_I};
            end
         end
         CLS_LOAD: begin
            range_err = !fits_signed(imm, 12);
            word      = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
         end
         CLS_STORE: begin
            range_err = !fits_signed(imm, 12);
            word      = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
         end
         CLS_BRANCH: begin
            range_err = !fits_signed(imm, 13) || imm[0];
            word      = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
         end
         CLS_LUI: begin
            range_err = |imm[11:0];
            word      = {imm[31:12], rd, OPC_LUI};
         end
         CLS_AUIPC: begin
            range_err = |imm[11:0];
            word      = {imm[31:12], rd, OPC_AUIPC};
         end
         CLS_JAL: begin
            range_err = !fits_signed(imm, 21) || imm[0];
            word      = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
         end
         CLS_JALR: begin
            range_err = !fits_signed(imm, 12);
            word      = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
         end
         CLS_LI: begin
            if (fits_signed(imm, 12)) begin
               word = {imm[11:0], 5'd0, 3'b000, rd, OPC_I};
            end else begin
               word     = lui_word;
               two_word = |imm[11:0];
            end
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes descriptors into RV32I words and streams them
// into instruction memory through a write port with backpressure.
//   clk, rst                : clock, synchronous active-high reset
//   in_valid/in_ready       : descriptor handshake
//   in_class..in_imm        : descriptor fields
//   mem_we/mem_ready        : memory write handshake
//   mem_addr/mem_wdata      : byte address and word of the held write
//   start/start_addr        : reload the address counter (deferred to sequence end)
//   word_count              : saturating count of completed writes
//   err_illegal/err_range   : one-cycle pulses for dropped descriptors
module instr_encoder_loader
   import encoder_pkg::*;
#(
   parameter int unsigned ADDR_W    = 12,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_class,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [2:0]        in_funct3,
   input  logic              in_alt,
   input  logic [31:0]       in_imm,
   output logic              mem_we,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   output logic [15:0]       word_count,
   output logic              err_illegal,
   output logic              err_range
);

   state_e            state_q;
   logic              we_q;
   logic [31:0]       wdata_q;
   logic [31:0]       pend_q;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       count_q, count_d;
   logic              start_pend_q;
   logic [ADDR_W-1:0] start_addr_q;
   logic              err_ill_q, err_rng_q;

   logic [31:0] pk_word, pk_lui, pk_addi;
   logic        pk_two, pk_rng, pk_ill;
   logic        seq_end, fire, accept_ok, done, apply_start;
   logic [ADDR_W-1:0] start_val;

   instr_field_packer u_packer (
      .cls       (in_class),
      .rd        (in_rd),
      .rs1       (in_rs1),
      .rs2       (in_rs2),
      .funct3    (in_funct3),
      .alt       (in_alt),
      .imm       (in_imm),
      .word      (pk_word),
      .lui_word  (pk_lui),
      .addi_word (pk_addi),
      .two_word  (pk_two),
      .range_err (pk_rng),
      .illegal   (pk_ill)
   );

   // A sequence is finished when nothing is held, or the last held word completes now.
   assign seq_end     = (state_q == IDLE) || ((state_q == HOLD) && mem_ready);
   assign in_ready    = seq_end;
   assign fire        = in_valid && in_ready;
   assign accept_ok   = fire && !pk_ill && !pk_rng;
   assign done        = we_q && mem_ready;
   // A fresh start request takes priority over an older deferred one.
   assign start_val   = start ? start_addr : start_addr_q;
   assign apply_start = (start || start_pend_q) && seq_end;

   always_comb begin
      addr_d  = addr_q;
      count_d = count_q;
      if (apply_start) begin
         addr_d  = start_val;
         count_d = '0;
      end else if (done) begin
         addr_d = addr_q + ADDR_W'(4);
         if (count_q != '1) count_d = count_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         we_q         <= 1'b0;
         wdata_q      <= '0;
         pend_q       <= '0;
         addr_q       <= ADDR_W'(BASE_ADDR);
         count_q      <= '0;
         start_pend_q <= 1'b0;
         start_addr_q <= '0;
         err_ill_q    <= 1'b0;
         err_rng_q    <= 1'b0;
      end else begin
         addr_q    <= addr_d;
         count_q   <= count_d;
         err_ill_q <= fire && pk_ill;
         err_rng_q <= fire && !pk_ill && pk_rng;
         if (apply_start) begin
            start_pend_q <= 1'b0;
         end else if (start) begin
            start_pend_q <= 1'b1;
            start_addr_q <= start_addr;
         end
         case (state_q)
            IDLE, HOLD: begin
               if (accept_ok) begin
                  wdata_q <= pk_two ? pk_lui : pk_word;
                  pend_q  <= pk_addi;
                  we_q    <= 1'b1;
                  state_q <= pk_two ? HOLD_LUI : HOLD;
               end else if ((state_q == HOLD) && mem_ready) begin
                  we_q    <= 1'b0;
                  state_q <= IDLE;
               end
            end
            HOLD_LUI: begin
               if (mem_ready) begin
                  wdata_q <= pend_q;
                  state_q <= HOLD;
               end
            end
            default: begin
               we_q    <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign mem_we      = we_q;
   assign mem_addr    = addr_q;
   assign mem_wdata   = wdata_q;
   assign word_count  = count_q;
   assign err_illegal = err_ill_q;
   assign err_range   = err_rng_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [3:0]  in_class = '0;
   logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
   logic [2:0]  in_funct3 = '0;
   logic        in_alt = 1'b0;
   logic [31:0] in_imm = '0;
   logic        mem_ready = 1'b1;
   logic        start = 1'b0;
   logic [11:0] start_addr = '0;

   logic        in_ready, mem_we, err_illegal, err_range;
   logic [11:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [15:0] word_count;

   logic        in_ready4, mem_we4, err_illegal4, err_range4;
   logic [3:0]  mem_addr4;
   logic [31:0] mem_wdata4;
   logic [15:0] word_count4;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [31:0]  q[$];
   int unsigned  exp_addr = 0;
   logic [15:0]  exp_count = '0;
   bit           exp_ill = 0, exp_rng = 0, m_pend = 0;
   logic [11:0]  m_paddr = '0;

   always #5 clk = ~clk;

   instr_encoder_loader #(.ADDR_W(12), .BASE_ADDR(0)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_alt(in_alt), .in_imm(in_imm),
      .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .start(start), .start_addr(start_addr), .word_count(word_count),
      .err_illegal(err_illegal), .err_range(err_range));

   instr_encoder_loader #(.ADDR_W(4), .BASE_ADDR(0)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
      .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_alt(in_alt), .in_imm(in_imm),
      .mem_we(mem_we4), .mem_ready(mem_ready), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
      .start(start), .start_addr(start_addr[3:0]), .word_count(word_count4),
      .err_illegal(err_illegal4), .err_range(err_range4));

   // Arithmetic RV32I encoder: returns n words (0 when dropped).
   function automatic void ref_encode(input logic [3:0] cls, input logic [4:0] rd, rs1, rs2,
                                      input logic [2:0] f3, input logic alt, input logic [31:0] imm,
                                      output int n, output logic [31:0] w0, output logic [31:0] w1,
                                      output bit ill, output bit rng);
      int s;
      logic [31:0] RD, RS1, RS2, F3, F7, hi;
      s = $signed(imm);
      RD = 32'(rd); RS1 = 32'(rs1); RS2 = 32'(rs2); F3 = 32'(f3);
      F7 = alt ? 32'h4000_0000 : 32'h0;
      n = 1; w0 = '0; w1 = '0; ill = 0; rng = 0;
      case (cls)
         4'd0: w0 = 32'h33 | (RD << 7) | (F3 << 12) | (RS1 << 15) | (RS2 << 20) | F7;
         4'd1: begin
            if (f3 == 3'd1 || f3 == 3'd5) begin
               rng = imm > 32'd31;
               w0 = 32'h13 | (RD << 7) | (F3 << 12) | (RS1 << 15) | ((imm & 32'h1F) << 20) | F7;
            end else begin
               rng = s < -2048 || s > 2047;
               w0 = 32'h13 | (RD << 7) | (F3 << 12) | (RS1 << 15) | ((imm & 32'hFFF) << 20);
            end
         end
         4'd2: begin
            rng = s < -2048 || s > 2047;
            w0 = 32'h03 | (RD << 7) | (F3 << 12) | (RS1 << 15) | ((imm & 32'hFFF) << 20);
         end
         4'd3: begin
            rng = s < -2048 || s > 2047;
            w0 = 32'h23 | ((imm & 32'h1F) << 7) | (F3 << 12) | (RS1 << 15) | (RS2 << 20)
                 | (((imm >> 5) & 32'h7F) << 25);
         end
         4'd4: begin
            rng = s < -4096 || s > 4094 || imm[0];
            w0 = 32'h63 | (((imm >> 11) & 1) << 7) | (((imm >> 1) & 32'hF) << 8) | (F3 << 12)
                 | (RS1 << 15) | (RS2 << 20) | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 12) & 1) << 31);
         end
         4'd5, 4'd6: begin
            rng = (imm & 32'hFFF) != 0;
            w0 = (imm & 32'hFFFF_F000) | (RD << 7) | ((cls == 4'd5) ? 32'h37 : 32'h17);
         end
         4'd7: begin
            rng = s < -(1 << 20) || s > (1 << 20) - 2 || imm[0];
            w0 = 32'h6F | (RD << 7) | (((imm >> 12) & 32'hFF) << 12) | (((imm >> 11) & 1) << 20)
                 | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 20) & 1) << 31);
         end
         4'd8: begin
            rng = s < -2048 || s > 2047;
            w0 = 32'h67 | (RD << 7) | (RS1 << 15) | ((imm & 32'hFFF) << 20);
         end
         4'd9: begin
            if (s >= -2048 && s <= 2047) begin
               w0 = 32'h13 | (RD << 7) | ((imm & 32'hFFF) << 20);
            end else begin
               hi = (imm + 32'h800) >> 12;
               w0 = (hi << 12) | (RD << 7) | 32'h37;
               if ((imm & 32'hFFF) != 0) begin
                  w1 = 32'h13 | (RD << 7) | (RD << 15) | ((imm & 32'hFFF) << 20);
                  n = 2;
               end
            end
         end
         default: ill = 1;
      endcase
      if (ill || rng) n = 0;
   endfunction

   // Advance one clock edge and update the model from the pre-edge inputs.
   task automatic clk_step();
      bit fire, wr, seq_end, st, r, ill, rng;
      int n;
      logic [31:0] w0, w1;
      logic [11:0] sa;
      seq_end = (q.size() == 0) || (q.size() == 1 && mem_ready);
      fire = in_valid && seq_end;
      wr = (q.size() > 0) && mem_ready;
      st = start; sa = start_addr; r = rst;
      ref_encode(in_class, in_rd, in_rs1, in_rs2, in_funct3, in_alt, in_imm, n, w0, w1, ill, rng);
      @(posedge clk); #1;
      if (r) begin
         q.delete(); exp_addr = 0; exp_count = '0; exp_ill = 0; exp_rng = 0; m_pend = 0;
      end else begin
         exp_ill = fire && ill;
         exp_rng = fire && !ill && rng;
         if (wr) begin
            void'(q.pop_front());
            exp_addr = (exp_addr + 4) % 4096;
            if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
         end
         if (fire && n >= 1) q.push_back(w0);
         if (fire && n == 2) q.push_back(w1);
         if ((st || m_pend) && seq_end) begin
            exp_addr = st ? 32'(sa) : 32'(m_paddr); exp_count = '0; m_pend = 0;
         end else if (st) begin
            m_pend = 1; m_paddr = sa;
         end
      end
   endtask

   task automatic set_desc(input logic [3:0] c, input logic [4:0] rd, rs1, rs2,
                           input logic [2:0] f3, input logic alt, input logic [31:0] imm);
      in_class = c; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_funct3 = f3; in_alt = alt; in_imm = imm;
   endtask

   task automatic test_reset();
      rst = 1; in_valid = 0; mem_ready = 1; start = 0;
      clk_step(); clk_step();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b exp 0", mem_we); end
      checks++; if (mem_addr !== 12'h000) begin errors++; $display("FAIL reset_addr got %h exp 000", mem_addr); end
      checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h exp 0", mem_wdata); end
      checks++; if (word_count !== 16'h0) begin errors++; $display("FAIL reset_count got %h exp 0", word_count); end
      checks++; if ({err_illegal, err_range} !== 2'b00) begin errors++; $display("FAIL reset_err got %b%b exp 00", err_illegal, err_range); end
      rst = 0;
   endtask

   task automatic test_add();
      mem_ready = 1;
      set_desc(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0); in_valid = 1;
      clk_step(); in_valid = 0;
      checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL add_we got %b exp 1", mem_we); end
      checks++; if (mem_wdata !== 32'h002081B3) begin errors++; $display("FAIL add_word got %h exp 002081b3", mem_wdata); end
      checks++; if (mem_addr !== 12'h000) begin errors++; $display("FAIL add_addr got %h exp 000", mem_addr); end
      clk_step();
      checks++; if (word_count !== 16'd1) begin errors++; $display("FAIL add_count got %0d exp 1", word_count); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL add_idle_we got %b exp 0", mem_we); end
   endtask

   task automatic test_li();
      logic [31:0] imms[3] = '{32'h12345678, 32'h00000FFF, 32'hFFFFFFFB};
      logic [31:0] w0s[3]  = '{32'h123452B7, 32'h000012B7, 32'hFFB00293};
      logic [31:0] w1s[3]  = '{32'h67828293, 32'hFFF28293, 32'h0};
      int unsigned a;
      mem_ready = 1;
      for (int i = 0; i < 3; i++) begin
         a = exp_addr;
         set_desc(4'd9, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, imms[i]); in_valid = 1;
         clk_step(); in_valid = 0;
         checks++; if (mem_wdata !== w0s[i]) begin errors++; $display("FAIL li%0d_w0 got %h exp %h", i, mem_wdata, w0s[i]); end
         checks++; if (mem_addr !== 12'(a)) begin errors++; $display("FAIL li%0d_a0 got %h exp %h", i, mem_addr, 12'(a)); end
         checks++; if (in_ready !== (i == 2)) begin errors++; $display("FAIL li%0d_ready got %b exp %b", i, in_ready, i == 2); end
         clk_step();
         if (i < 2) begin
            checks++; if (mem_wdata !== w1s[i] || mem_we !== 1'b1) begin errors++; $display("FAIL li%0d_w1 got %h/%b exp %h/1", i, mem_wdata, mem_we, w1s[i]); end
            checks++; if (mem_addr !== 12'(a + 4)) begin errors++; $display("FAIL li%0d_a1 got %h exp %h", i, mem_addr, 12'(a + 4)); end
            clk_step();
         end
         checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL li%0d_end_we got %b exp 0", i, mem_we); end
      end
   endtask

   task automatic test_branch_range();
      logic [15:0] cnt;
      mem_ready = 1;
      set_desc(4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd8); in_valid = 1;
      clk_step(); in_valid = 0;
      checks++; if (mem_wdata !== 32'h00208463) begin errors++; $display("FAIL beq_word got %h exp 00208463", mem_wdata); end
      clk_step();
      cnt = exp_count;
      set_desc(4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd7); in_valid = 1;
      clk_step(); in_valid = 0;
      checks++; if (err_range !== 1'b1) begin errors++; $display("FAIL beq7_err got %b exp 1", err_range); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL beq7_we got %b exp 0", mem_we); end
      clk_step();
      checks++; if (err_range !== 1'b0) begin errors++; $display("FAIL beq7_pulse got %b exp 0", err_range); end
      checks++; if (word_count !== cnt) begin errors++; $display("FAIL beq7_count got %0d exp %0d", word_count, cnt); end
   endtask

   task automatic test_backpressure();
      int unsigned a;
      mem_ready = 0;
      a = exp_addr;
      set_desc(4'd0, 5'd4, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0); in_valid = 1;
      clk_step();
      set_desc(4'd1, 5'd6, 5'd0, 5'd0, 3'd0, 1'b0, 32'd100);
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp%0d_ready got %b exp 0", i, in_ready); end
         checks++; if (mem_we !== 1'b1 || mem_wdata !== 32'h40208233) begin errors++; $display("FAIL bp%0d_word got %h exp 40208233", i, mem_wdata); end
         checks++; if (mem_addr !== 12'(a)) begin errors++; $display("FAIL bp%0d_addr got %h exp %h", i, mem_addr, 12'(a)); end
         clk_step();
      end
      mem_ready = 1;
      clk_step(); in_valid = 0;
      checks++; if (mem_we !== 1'b1 || mem_wdata !== 32'h06400313) begin errors++; $display("FAIL bp_next_word got %h exp 06400313", mem_wdata); end
      checks++; if (mem_addr !== 12'(a + 4)) begin errors++; $display("FAIL bp_next_addr got %h exp %h", mem_addr, 12'(a + 4)); end
      clk_step();
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL bp_end_we got %b exp 0", mem_we); end
   endtask

   task automatic test_wrap_illegal();
      mem_ready = 1;
      start = 1; start_addr = 12'h00C;
      clk_step(); start = 0;
      checks++; if (word_count4 !== 16'd0 || mem_addr4 !== 4'hC) begin errors++; $display("FAIL wrap_start got %h/%0d exp c/0", mem_addr4, word_count4); end
      set_desc(4'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'h00001000); in_valid = 1;
      clk_step();
      checks++; if (mem_addr4 !== 4'hC || mem_wdata4 !== 32'h000010B7) begin errors++; $display("FAIL wrap_first got %h/%h exp c/000010b7", mem_addr4, mem_wdata4); end
      set_desc(4'd1, 5'd2, 5'd1, 5'd0, 3'd0, 1'b0, 32'd5);
      clk_step(); in_valid = 0;
      checks++; if (mem_addr4 !== 4'h0 || mem_we4 !== 1'b1) begin errors++; $display("FAIL wrap_second got %h/%b exp 0/1", mem_addr4, mem_we4); end
      checks++; if (mem_addr !== 12'h010) begin errors++; $display("FAIL wrap_main got %h exp 010", mem_addr); end
      clk_step();
      set_desc(4'd12, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 32'd0); in_valid = 1;
      clk_step(); in_valid = 0;
      checks++; if (err_illegal !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL illegal got err %b we %b exp 1/0", err_illegal, mem_we); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL illegal_ready got %b exp 1", in_ready); end
      clk_step();
      checks++; if (err_illegal !== 1'b0) begin errors++; $display("FAIL illegal_pulse got %b exp 0", err_illegal); end
   endtask

   task automatic test_start_deferred();
      int unsigned a;
      mem_ready = 0; a = exp_addr;
      set_desc(4'd9, 5'd8, 5'd0, 5'd0, 3'd0, 1'b0, 32'h00012345); in_valid = 1;
      clk_step(); in_valid = 0;
      start = 1; start_addr = 12'h100;
      clk_step(); start = 0;
      checks++; if (mem_addr !== 12'(a)) begin errors++; $display("FAIL defer_hold_addr got %h exp %h", mem_addr, 12'(a)); end
      mem_ready = 1;
      clk_step();
      checks++; if (mem_addr !== 12'(a + 4) || mem_wdata !== 32'h34540413) begin errors++; $display("FAIL defer_addi got %h/%h exp %h/34540413", mem_addr, mem_wdata, 12'(a + 4)); end
      clk_step();
      checks++; if (mem_addr !== 12'h100 || word_count !== 16'd0) begin errors++; $display("FAIL defer_apply got %h/%0d exp 100/0", mem_addr, word_count); end
   endtask

   task automatic test_reset_lui();
      mem_ready = 0;
      set_desc(4'd9, 5'd7, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345678); in_valid = 1;
      clk_step(); in_valid = 0;
      clk_step();
      rst = 1;
      clk_step(); rst = 0;
      checks++; if (mem_we !== 1'b0 || mem_addr !== 12'h000 || word_count !== 16'd0) begin errors++; $display("FAIL rst_lui got we %b addr %h cnt %0d exp 0/000/0", mem_we, mem_addr, word_count); end
      mem_ready = 1;
      for (int i = 0; i < 2; i++) begin
         clk_step();
         checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_lui_nowrite%0d got %b exp 0", i, mem_we); end
      end
   endtask

   task automatic test_random_stream();
      logic [31:0] bnd[13] = '{32'd2047, 32'hFFFFF800, 32'd2048, 32'hFFFFF7FF, 32'd4094, 32'hFFFFF000,
                               32'd4096, 32'd31, 32'd32, 32'd0, 32'h000FFFFE, 32'hFFF00000, 32'h00100000};
      logic [31:0] imm;
      bit rdy;
      for (int i = 0; i < 800; i++) begin
         case ($urandom_range(0, 4))
            0: imm = 32'($urandom_range(0, 63)) - 32'd32;
            1: imm = $urandom();
            2: imm = bnd[$urandom_range(0, 12)];
            3: imm = $urandom() & 32'hFFFFF000;
            default: imm = (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'(($urandom_range(0, 1)));
         endcase
         set_desc(4'($urandom_range(0, 11)), 5'($urandom()), 5'($urandom()), 5'($urandom()),
                  3'($urandom()), 1'($urandom()), imm);
         in_valid = ($urandom_range(0, 9) < 6);
         mem_ready = ($urandom_range(0, 9) < 7);
         start = ($urandom_range(0, 29) == 0);
         start_addr = 12'($urandom_range(0, 1023) * 4);
         rst = ($urandom_range(0, 199) == 0);
         #1;
         rdy = (q.size() == 0) || (q.size() == 1 && mem_ready);
         checks++; if (in_ready !== rdy || in_ready4 !== rdy) begin errors++; $display("FAIL rnd%0d_ready got %b/%b exp %b", i, in_ready, in_ready4, rdy); end
         clk_step();
         checks++; if (mem_we !== (q.size() > 0) || mem_we4 !== (q.size() > 0)) begin errors++; $display("FAIL rnd%0d_we got %b/%b exp %b", i, mem_we, mem_we4, q.size() > 0); end
         if (q.size() > 0) begin
            checks++; if (mem_wdata !== q[0] || mem_wdata4 !== q[0]) begin errors++; $display("FAIL rnd%0d_word got %h/%h exp %h", i, mem_wdata, mem_wdata4, q[0]); end
         end
         checks++; if (mem_addr !== 12'(exp_addr) || mem_addr4 !== 4'(exp_addr)) begin errors++; $display("FAIL rnd%0d_addr got %h/%h exp %h", i, mem_addr, mem_addr4, 12'(exp_addr)); end
         checks++; if (word_count !== exp_count || word_count4 !== exp_count) begin errors++; $display("FAIL rnd%0d_count got %0d/%0d exp %0d", i, word_count, word_count4, exp_count); end
         checks++; if (err_illegal !== exp_ill || err_range !== exp_rng || err_illegal4 !== exp_ill || err_range4 !== exp_rng) begin
            errors++; $display("FAIL rnd%0d_err got %b%b exp %b%b", i, err_illegal, err_range, exp_ill, exp_rng); end
      end
      rst = 0; start = 0; in_valid = 0;
   endtask

   initial begin
      test_reset();
      test_add();
      test_li();
      test_branch_range();
      test_backpressure();
      test_wrap_illegal();
      test_start_deferred();
      test_reset_lui();
      test_random_stream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the control/field decoder: accepts decoded instruction descriptors and encodes each into an RV32I 32-bit word.
- Writes the words sequentially into instruction memory through a write port with backpressure.
- Expands the LI pseudo-op into LUI+ADDI.
- Used for program loading and self-test stimulus in front of the pipeline core's instruction memory.

Parameters:
ADDR_W, 12, byte-address width of the instruction memory write port
BASE_ADDR, 0, mem_addr value after reset

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  descriptor valid
in_ready  out  1  descriptor accepted when in_valid && in_ready
in_class  in  4  0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 LUI, 6 AUIPC, 7 JAL, 8 JALR, 9 LI; 10-15 illegal
in_rd  in  5  destination register
in_rs1  in  5  source 1
in_rs2  in  5  source 2
in_funct3  in  3  funct3
in_alt  in  1  funct7[5] (SUB/SRA/SRAI)
in_imm  in  32  signed immediate, byte units
mem_we  out  1  write request; word valid
mem_ready  in  1  memory accepts write when mem_we && mem_ready
mem_addr  out  ADDR_W  byte address of current word
mem_wdata  out  32  encoded instruction
start  in  1  load start_addr into the address counter
start_addr  in  ADDR_W  new base address
word_count  out  16  words written since reset/start
err_illegal  out  1  one-cycle pulse: illegal class dropped
err_range  out  1  one-cycle pulse: immediate out of range, dropped

Behaviour:
- Reset values: in_ready=1, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, word_count=0, err_*=0, state=IDLE.
- Reset mid-operation: any held or pending word is discarded; nothing is written in the cycle after rst.
- States:
  - IDLE: no word held.
  - HOLD: one word held on mem_wdata with mem_we=1.
  - HOLD_LUI: LUI word held, ADDI pending.
- in_ready = (state==IDLE) || (state==HOLD && mem_ready). Allows 1 word/cycle streaming. in_ready=0 in HOLD_LUI.
- Latency: a descriptor accepted at edge N drives mem_we/mem_wdata in the cycle following edge N.
- While mem_we && !mem_ready: mem_wdata and mem_addr are held stable.
- On each completed write:
  - mem_addr += 4, wrapping modulo 2^ADDR_W.
  - word_count += 1, saturating at 0xFFFF.
- HOLD_LUI write completes -> HOLD with the ADDI word.
- Field packing: opcodes R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111.
  - R: funct7 = in_alt ? 0100000 : 0.
  - I-ALU with funct3 001/101: imm[11:5] = in_alt ? 0100000 : 0; imm[4:0] = in_imm[4:0].
  - JALR: funct3 forced to 000.
- Range checks. Failure drops the descriptor, pulses err_range, and leaves addr/count unchanged.
  - I/S/JALR: in_imm must be a 12-bit signed value.
  - B: 13-bit signed, bit0=0.
  - J: 21-bit signed, bit0=0.
  - Shift imm: 0..31.
  - U: in_imm[11:0] must be 0; the field is in_imm[31:12].
- LI:
  - If in_imm fits 12-bit signed: single ADDI rd,x0,imm.
  - Else: hi=(in_imm+0x800)>>12 (32-bit wrap). Emit LUI rd,hi, then ADDI rd,rd,in_imm[11:0].
  - ADDI is omitted when in_imm[11:0]==0.
  - LI never raises err_range.
- Illegal class: dropped, err_illegal pulses the cycle after acceptance, in_ready unaffected.
- start:
  - In IDLE: loads mem_addr, clears word_count.
  - Otherwise the load takes effect after the current sequence, including a pending ADDI, finishes writing.
  - start and rst together: rst wins.
  - start with a same-cycle completed write: start_addr wins; count clears.

Decomposition:
- Shared package encoder_pkg: class codes, the nine 7-bit opcode constants, state enum (IDLE/HOLD/HOLD_LUI), 32-bit NOP constant 0x00000013.
- Sub-module instr_field_packer: purely combinational.
  - Inputs: descriptor.
  - Outputs: word, lui_word, addi_word, two_word flag, range_err, illegal.
- The top module holds the FSM, address/count registers, and handshake.

Test Plan:
1. ADD x3,x1,x2 (class 0, f3 0, alt 0) at BASE 0 -> mem_addr 0x000, mem_wdata 0x002081B3, word_count 1.
2. LI x5,0x12345678 -> 0x123452B7 @0x000, then 0x67828293 @0x004. LI x5,0x00000FFF -> 0x000012B7, then 0xFFF28293. LI x5,-5 -> single 0xFFB00293.
3. BEQ x1,x2,+8 -> 0x00208463. BEQ with imm 7 -> err_range pulse, no mem_we, word_count unchanged.
4. Backpressure: hold mem_ready=0 for 3 cycles with a queued descriptor -> mem_wdata/mem_addr stable, in_ready=0. On release, back-to-back writes at consecutive +4 addresses.
5. Wrap with ADDR_W=4 and start_addr 0xC: two writes -> addresses 0xC, 0x0. class 12 -> err_illegal, no write.
6. Assert rst while in HOLD_LUI -> next cycle mem_we=0, mem_addr=BASE_ADDR, word_count=0, and the pending ADDI is never written.
